// File: rtl/pipeline_control.sv
// Sequencing and hazard controller for the IF/ID -> ID/EX -> EX/WB pipeline:
// PC control, pipeline-register clears, EX operand forwarding and retire counting.
module pipeline_control #(
    parameter int ADDR_W       = 8,
    parameter int INIT_CYCLES  = 3,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_req,
    input  logic [1:0]        id_opcode,
    input  logic [2:0]        id_rDest,
    input  logic [2:0]        id_rSrc,
    input  logic [ADDR_W-1:0] id_jump_address,
    input  logic [1:0]        exe_opcode,
    input  logic [2:0]        exe_rDest,
    output logic              pc_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              if_id_reset,
    output logic              id_exe_reset,
    output logic              exe_wb_reset,
    output logic              fwd_dest,
    output logic              fwd_src,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int MAX_CYC = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
    localparam int SEQ_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [SEQ_W-1:0] INIT_LAST  = SEQ_W'(INIT_CYCLES - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEQ_W-1:0] cnt;
    logic [SEQ_W-1:0] cnt_nxt;
    logic             active;
    logic             jump;
    logic             wb_writes;
    logic             retire_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_INIT;
            cnt          <= '0;
            retire_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (retire_en) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_INIT: begin
                if (cnt == INIT_LAST) begin
                    state_nxt = halt_req ? S_DRAIN : S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                // halt_req is deliberately ignored until the drain completes
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_HALTED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset overrides everything so no PC load escapes on the reset cycle.
    assign active    = !reset && (state != S_INIT);
    assign jump      = (id_opcode == 2'b11);
    assign wb_writes = (exe_opcode == 2'b01) || (exe_opcode == 2'b10);
    assign retire_en = (state != S_INIT) && (exe_opcode != 2'b00);

    always_comb begin
        pc_en        = 1'b0;
        pc_load      = 1'b0;
        pc_next      = '0;
        if_id_reset  = 1'b1;
        id_exe_reset = 1'b1;
        exe_wb_reset = 1'b1;
        fwd_dest     = 1'b0;
        fwd_src      = 1'b0;
        halted       = 1'b0;
        if (active) begin
            exe_wb_reset = 1'b0;
            id_exe_reset = jump;
            if_id_reset  = jump || (state != S_RUN);
            pc_en        = (state == S_RUN) && !jump;
            pc_load      = jump;
            pc_next      = jump ? id_jump_address : '0;
            halted       = (state == S_HALTED);
            fwd_dest     = wb_writes && (exe_rDest == id_rDest) && (id_opcode == 2'b01);
            fwd_src      = wb_writes && (exe_rDest == id_rSrc) && (id_opcode == 2'b01);
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model of the controller.
module tb_pipeline_control;

    localparam int ADDR_W       = 8;
    localparam int INIT_CYCLES  = 3;
    localparam int DRAIN_CYCLES = 2;
    localparam int CNT_W        = 16;

    localparam int MODE_INIT   = 0;
    localparam int MODE_RUN    = 1;
    localparam int MODE_DRAIN  = 2;
    localparam int MODE_HALTED = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              halt_req;
    logic [1:0]        id_opcode;
    logic [2:0]        id_rDest;
    logic [2:0]        id_rSrc;
    logic [ADDR_W-1:0] id_jump_address;
    logic [1:0]        exe_opcode;
    logic [2:0]        exe_rDest;
    logic              pc_en;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;
    logic              if_id_reset;
    logic              id_exe_reset;
    logic              exe_wb_reset;
    logic              fwd_dest;
    logic              fwd_src;
    logic              halted;
    logic [CNT_W-1:0]  retire_count;

    always #5 clk = ~clk;

    pipeline_control #(
        .ADDR_W      (ADDR_W),
        .INIT_CYCLES (INIT_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .halt_req       (halt_req),
        .id_opcode      (id_opcode),
        .id_rDest       (id_rDest),
        .id_rSrc        (id_rSrc),
        .id_jump_address(id_jump_address),
        .exe_opcode     (exe_opcode),
        .exe_rDest      (exe_rDest),
        .pc_en          (pc_en),
        .pc_load        (pc_load),
        .pc_next        (pc_next),
        .if_id_reset    (if_id_reset),
        .id_exe_reset   (id_exe_reset),
        .exe_wb_reset   (exe_wb_reset),
        .fwd_dest       (fwd_dest),
        .fwd_src        (fwd_src),
        .halted         (halted),
        .retire_count   (retire_count)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: current mode, cycles left in a timed mode, retired total.
    int               m_mode;
    int               m_left;
    logic [CNT_W-1:0] m_retired;
    logic             last_pc_en;
    logic             last_all_reset;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        halt_req        = 1'b0;
        id_opcode       = 2'b00;
        id_rDest        = 3'd0;
        id_rSrc         = 3'd0;
        id_jump_address = '0;
        exe_opcode      = 2'b00;
        exe_rDest       = 3'd0;
    endtask

    task automatic check_outputs();
        logic act;
        logic jmp;
        logic wb;
        logic running;
        act     = !reset && (m_mode != MODE_INIT);
        jmp     = act && (id_opcode == 2'b11);
        wb      = (exe_opcode == 2'b01) || (exe_opcode == 2'b10);
        running = act && (m_mode == MODE_RUN);
        check("pc_en",        32'(pc_en),        32'(running && !jmp));
        check("pc_load",      32'(pc_load),      32'(jmp));
        check("pc_next",      32'(pc_next),      jmp ? 32'(id_jump_address) : 32'd0);
        check("if_id_reset",  32'(if_id_reset),  32'(!act || jmp || !running));
        check("id_exe_reset", 32'(id_exe_reset), 32'(!act || jmp));
        check("exe_wb_reset", 32'(exe_wb_reset), 32'(!act));
        check("fwd_dest",     32'(fwd_dest),
              32'(act && wb && id_opcode == 2'b01 && exe_rDest == id_rDest));
        check("fwd_src",      32'(fwd_src),
              32'(act && wb && id_opcode == 2'b01 && exe_rDest == id_rSrc));
        check("halted",       32'(halted),       32'(act && m_mode == MODE_HALTED));
        check("retire_count", 32'(retire_count), 32'(m_retired));
    endtask

    task automatic model_step();
        if (reset) begin
            m_mode    = MODE_INIT;
            m_left    = INIT_CYCLES;
            m_retired = '0;
        end else begin
            if (m_mode != MODE_INIT && exe_opcode != 2'b00) m_retired = m_retired + 1'b1;
            case (m_mode)
                MODE_INIT: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (halt_req) begin
                            m_mode = MODE_DRAIN;
                            m_left = DRAIN_CYCLES;
                        end else begin
                            m_mode = MODE_RUN;
                        end
                    end
                end
                MODE_RUN: begin
                    if (halt_req) begin
                        m_mode = MODE_DRAIN;
                        m_left = DRAIN_CYCLES;
                    end
                end
                MODE_DRAIN: begin
                    m_left--;
                    if (m_left == 0) m_mode = MODE_HALTED;
                end
                default: begin
                    if (!halt_req) m_mode = MODE_RUN;
                end
            endcase
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        #1;
        check_outputs();
        last_pc_en     = pc_en;
        last_all_reset = if_id_reset && id_exe_reset && exe_wb_reset;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (INIT_CYCLES) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int guard;
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_mode    = MODE_INIT;
        m_left    = INIT_CYCLES;
        m_retired = '0;
        tick();
        reset = 1'b0;

        // Warm-up length: cycles with pc_en low and every pipeline register cleared.
        n     = 0;
        guard = 0;
        do begin
            tick();
            if (!last_pc_en && last_all_reset) n++;
            guard++;
        end while (!last_pc_en && guard < 20);
        check("init_len", 32'(n), 32'(INIT_CYCLES));
        check("init_then_run", 32'(last_pc_en), 32'd1);

        // Jump in RUN.
        id_opcode       = 2'b11;
        id_jump_address = 8'h40;
        #1;
        check("jmp_pc_load", 32'(pc_load), 32'd1);
        check("jmp_pc_next", 32'(pc_next), 32'h40);
        check("jmp_pc_en", 32'(pc_en), 32'd0);
        check("jmp_flush", 32'({if_id_reset, id_exe_reset, exe_wb_reset}), 32'b110);
        tick();
        idle();
        #1;
        check("post_jmp_flush", 32'({if_id_reset, id_exe_reset}), 32'b00);
        check("post_jmp_pc_en", 32'(pc_en), 32'd1);
        tick();

        // Forwarding.
        exe_opcode = 2'b10;
        exe_rDest  = 3'd3;
        id_opcode  = 2'b01;
        id_rDest   = 3'd3;
        id_rSrc    = 3'd3;
        #1;
        check("fwd_both_dest", 32'(fwd_dest), 32'd1);
        check("fwd_both_src", 32'(fwd_src), 32'd1);
        id_rSrc = 3'd2;
        #1;
        check("fwd_src_miss", 32'(fwd_src), 32'd0);
        check("fwd_dest_hit", 32'(fwd_dest), 32'd1);
        exe_opcode = 2'b00;
        #1;
        check("fwd_nop", 32'({fwd_dest, fwd_src}), 32'd0);
        tick();
        idle();

        // Retire counting: 5 non-NOP then 3 NOP.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exe_opcode = (i < 5) ? 2'(i % 3 + 1) : 2'b00;
            tick();
        end
        idle();
        #1;
        check("retire_5", 32'(retire_count), 32'd5);
        tick();

        // Halt, drain, halted, jump while halted, resume.
        halt_req = 1'b1;
        #1;
        check("halt_req_cycle_pc_en", 32'(pc_en), 32'd1);
        tick();
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            #1;
            check("drain_pc_en", 32'(pc_en), 32'd0);
            check("drain_halted", 32'(halted), 32'd0);
            check("drain_if_id_reset", 32'(if_id_reset), 32'd1);
            tick();
        end
        #1;
        check("halted_flag", 32'(halted), 32'd1);
        tick();
        id_opcode       = 2'b11;
        id_jump_address = 8'h55;
        #1;
        check("halted_jmp_load", 32'(pc_load), 32'd1);
        check("halted_jmp_next", 32'(pc_next), 32'h55);
        check("halted_jmp_pc_en", 32'(pc_en), 32'd0);
        tick();
        idle();
        tick();
        #1;
        check("resume_pc_en", 32'(pc_en), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);
        tick();

        // Reset during DRAIN with a jump pending.
        halt_req = 1'b1;
        tick();
        reset           = 1'b1;
        id_opcode       = 2'b11;
        id_jump_address = 8'h22;
        exe_opcode      = 2'b01;
        #1;
        check("rst_drain_pc_load", 32'(pc_load), 32'd0);
        check("rst_drain_pc_next", 32'(pc_next), 32'd0);
        check("rst_drain_exe_wb", 32'(exe_wb_reset), 32'd1);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("rst_drain_count", 32'(retire_count), 32'd0);
        check("rst_drain_init_pc_en", 32'(pc_en), 32'd0);
        check("rst_drain_init_id_exe", 32'(id_exe_reset), 32'd1);
        repeat (INIT_CYCLES) tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            id_opcode       = 2'($urandom_range(0, 3));
            id_rDest        = 3'($urandom_range(0, 7));
            id_rSrc         = 3'($urandom_range(0, 7));
            id_jump_address = 8'($urandom_range(0, 255));
            exe_opcode      = 2'($urandom_range(0, 3));
            exe_rDest       = 3'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0;

        // Retire counter wrap at 2^CNT_W.
        do_reset();
        exe_opcode = 2'b01;
        repeat ((1 << CNT_W) - 1) tick();
        #1;
        check("retire_max", 32'(retire_count), 32'hFFFF);
        tick();
        #1;
        check("retire_wrap", 32'(retire_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
